// File: rtl/mult_arb_pkg.sv
// mult_arb_pkg: shared types and constants for the multiplier-pipe arbiter.
//   MULT_W    - operand/result width of the shared doubler pipe
//   ID_MAX_W  - widest requester ID (N_REQ up to 8); narrower IDs are zero-extended
//   SAT_VAL   - saturated result of the doubler
//   tag_t     - {valid, id} carried alongside the pipe
//   sat_double- reference behaviour of the external doubler pipe
package mult_arb_pkg;

  localparam int MULT_W   = 8;
  localparam int ID_MAX_W = 3;

  localparam logic [MULT_W-1:0] SAT_VAL = 8'hFF;

  typedef struct packed {
    logic                valid;
    logic [ID_MAX_W-1:0] id;
  } tag_t;

  // Doubler reference: inputs >= 128 overflow 8 bits and clamp to SAT_VAL.
  function automatic logic [MULT_W-1:0] sat_double(input logic [MULT_W-1:0] x);
    return x[MULT_W-1] ? SAT_VAL : {x[MULT_W-2:0], 1'b0};
  endfunction

endpackage

// File: rtl/mult_arbiter_rr_arbiter.sv
// rr_arbiter: purely combinational round-robin grant selector.
//   req    in  N     - request vector
//   ptr    in  ID_W  - highest-priority index this cycle (always < N)
//   en     in  1     - when low no grant is produced
//   gnt    out N     - one-hot grant, or zero
//   gnt_id out ID_W  - encoded index of gnt (0 when no grant)
module rr_arbiter #(
  parameter int N    = 4,
  parameter int ID_W = $clog2(N)
) (
  input  logic [N-1:0]    req,
  input  logic [ID_W-1:0] ptr,
  input  logic            en,
  output logic [N-1:0]    gnt,
  output logic [ID_W-1:0] gnt_id
);

  logic [ID_W:0]   sum;
  logic [ID_W-1:0] idx;
  logic            found;

  // Scan ptr, ptr+1, ... wrapping at N. ptr < N and k < N, so a single
  // conditional subtraction is enough to bring the sum back into range.
  always_comb begin
    gnt    = '0;
    gnt_id = '0;
    found  = 1'b0;
    sum    = '0;
    idx    = '0;
    for (int k = 0; k < N; k++) begin
      sum = {1'b0, ptr} + (ID_W+1)'(k);
      if (sum >= (ID_W+1)'(N)) begin
        sum = sum - (ID_W+1)'(N);
      end
      idx = sum[ID_W-1:0];
      if (en && !found && req[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        gnt_id   = idx;
      end
    end
  end

endmodule

// File: rtl/mult_arbiter.sv
// mult_arbiter: shares one fixed-latency saturating-doubler pipe among N_REQ
// requesters and routes each result back to the requester that issued it.
//   clk, rst_n           - clock, synchronous active-low reset
//   en                   - arbitration enable (in-flight results still return)
//   req_valid/req_data   - per-requester request and 8-bit operand
//   req_ready            - one-hot grant
//   pipe_valid_in/_data_in   - towards the external pipe
//   pipe_valid_out/_data_out - from the external pipe
//   resp_valid/_id/_data - registered result strobe, owner ID and value
//   busy                 - a tag is in flight or a response is being presented
//   err                  - sticky: pipe valid disagreed with the tag pipeline
//
// Handshake: a requester transfers its operand in a cycle where
// req_valid[i] & req_ready[i]; req_ready depends only on req_valid, the
// round-robin pointer, en and rst_n. The response side has no ready:
// resp_valid is a single-cycle strobe that the consumer must take.
module mult_arbiter
  import mult_arb_pkg::*;
#(
  parameter int N_REQ    = 4,
  parameter int PIPE_LAT = 1,
  parameter int ID_W     = $clog2(N_REQ)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ*MULT_W-1:0] req_data,
  output logic [N_REQ-1:0]        req_ready,
  output logic                    pipe_valid_in,
  output logic [MULT_W-1:0]       pipe_data_in,
  input  logic                    pipe_valid_out,
  input  logic [MULT_W-1:0]       pipe_data_out,
  output logic                    resp_valid,
  output logic [ID_W-1:0]         resp_id,
  output logic [MULT_W-1:0]       resp_data,
  output logic                    busy,
  output logic                    err
);

  localparam int MASK_W = $clog2(PIPE_LAT + 1);

  logic [N_REQ-1:0]  gnt;
  logic [ID_W-1:0]   gnt_id;
  logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
  tag_t              tag_q [PIPE_LAT];
  tag_t              tag_in, tag_last;
  logic [MASK_W-1:0] mask_q, mask_d;
  logic              resp_valid_q, resp_valid_d;
  logic [ID_W-1:0]   resp_id_q, resp_id_d;
  logic [MULT_W-1:0] resp_data_q, resp_data_d;
  logic              err_q, err_d;
  logic              resp_fire, mismatch, any_tag;

  // Gating with rst_n keeps req_ready low during reset even though the
  // arbiter itself is combinational.
  rr_arbiter #(
    .N    (N_REQ),
    .ID_W (ID_W)
  ) u_rr (
    .req    (req_valid),
    .ptr    (rr_ptr_q),
    .en     (en & rst_n),
    .gnt    (gnt),
    .gnt_id (gnt_id)
  );

  assign req_ready     = gnt;
  assign pipe_valid_in = |(gnt & req_valid);
  assign pipe_data_in  = pipe_valid_in ? req_data[int'(gnt_id)*MULT_W +: MULT_W] : '0;

  assign tag_last = tag_q[PIPE_LAT-1];

  always_comb begin
    tag_in       = '0;
    tag_in.valid = pipe_valid_in;
    tag_in.id    = ID_MAX_W'(gnt_id);
  end

  always_comb begin
    any_tag = 1'b0;
    for (int i = 0; i < PIPE_LAT; i++) begin
      any_tag = any_tag | tag_q[i].valid;
    end
  end

  // Only a matching {pipe valid, tag valid} pair produces a response; any
  // disagreement raises err, except during the post-reset mask window where
  // results of requests issued before reset may still emerge from the pipe.
  assign resp_fire = pipe_valid_out & tag_last.valid;
  assign mismatch  = pipe_valid_out ^ tag_last.valid;

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (pipe_valid_in) begin
      rr_ptr_d = (gnt_id == ID_W'(N_REQ - 1)) ? '0 : gnt_id + 1'b1;
    end
    mask_d       = (mask_q != '0) ? mask_q - 1'b1 : mask_q;
    resp_valid_d = resp_fire;
    resp_id_d    = resp_fire ? tag_last.id[ID_W-1:0] : '0;
    resp_data_d  = resp_fire ? pipe_data_out : '0;
    err_d        = err_q | (mismatch & (mask_q == '0));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr_q     <= '0;
      mask_q       <= MASK_W'(PIPE_LAT);
      resp_valid_q <= 1'b0;
      resp_id_q    <= '0;
      resp_data_q  <= '0;
      err_q        <= 1'b0;
      for (int i = 0; i < PIPE_LAT; i++) begin
        tag_q[i] <= '0;
      end
    end else begin
      rr_ptr_q     <= rr_ptr_d;
      mask_q       <= mask_d;
      resp_valid_q <= resp_valid_d;
      resp_id_q    <= resp_id_d;
      resp_data_q  <= resp_data_d;
      err_q        <= err_d;
      tag_q[0]     <= tag_in;
      for (int i = 1; i < PIPE_LAT; i++) begin
        tag_q[i] <= tag_q[i-1];
      end
    end
  end

  // Upper ID bits of the last stage are always zero when N_REQ < 8.
  if (ID_W < ID_MAX_W) begin : g_id_hi
    logic unused_id_hi;
    assign unused_id_hi = ^tag_last.id[ID_MAX_W-1:ID_W];
  end

  assign resp_valid = resp_valid_q;
  assign resp_id    = resp_id_q;
  assign resp_data  = resp_data_q;
  assign err        = err_q;
  assign busy       = any_tag | resp_valid_q;

endmodule

// File: tb/tb_mult_arbiter.sv
// tb_mult_arbiter: directed, table-driven bench for mult_arbiter
// (N_REQ=4, PIPE_LAT=1) with a one-stage saturating-doubler pipe model.
module tb_mult_arbiter;
  import mult_arb_pkg::*;

  // ---------------- clock / reset / signals ----------------
  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic        pipe_valid_in;
  logic [7:0]  pipe_data_in;
  logic        pipe_valid_out;
  logic [7:0]  pipe_data_out;
  logic        resp_valid;
  logic [1:0]  resp_id;
  logic [7:0]  resp_data;
  logic        busy;
  logic        err;
  logic        force_pv;

  always #5 clk = ~clk;

  mult_arbiter #(
    .N_REQ    (4),
    .PIPE_LAT (1)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .en             (en),
    .req_valid      (req_valid),
    .req_data       (req_data),
    .req_ready      (req_ready),
    .pipe_valid_in  (pipe_valid_in),
    .pipe_data_in   (pipe_data_in),
    .pipe_valid_out (pipe_valid_out),
    .pipe_data_out  (pipe_data_out),
    .resp_valid     (resp_valid),
    .resp_id        (resp_id),
    .resp_data      (resp_data),
    .busy           (busy),
    .err            (err)
  );

  // External pipe: latency 1, not reset; force_pv injects a spurious valid.
  logic       pv_q = 1'b0;
  logic [7:0] pd_q = 8'h00;
  always @(posedge clk) begin
    pv_q <= pipe_valid_in;
    pd_q <= sat_double(pipe_data_in);
  end
  assign pipe_valid_out = pv_q | force_pv;
  assign pipe_data_out  = pd_q;

  // ---------------- scoreboard ----------------
  int          checks   = 0;
  int          failures = 0;
  logic [17:0] exp_q[$];   // {due_step[7:0], id[1:0], data[7:0]}

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic check_resp(input int k);
    logic [17:0] e;
    check($sformatf("busy_s%0d", k), 32'(busy), 32'(exp_q.size() != 0));
    if (exp_q.size() != 0 && int'(exp_q[0][17:10]) == k) begin
      e = exp_q.pop_front();
      check($sformatf("resp_valid_s%0d", k), 32'(resp_valid), 32'd1);
      check($sformatf("resp_id_s%0d", k), 32'(resp_id), 32'(e[9:8]));
      check($sformatf("resp_data_s%0d", k), 32'(resp_data), 32'(e[7:0]));
    end else begin
      check($sformatf("resp_idle_s%0d", k), 32'(resp_valid), 32'd0);
    end
    check($sformatf("err_s%0d", k), 32'(err), 32'd0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        en;
    logic [3:0]  rv;
    logic [31:0] data;       // {d3, d2, d1, d0}
    logic [3:0]  exp_ready;
    logic [7:0]  exp_pdata;
    logic [7:0]  exp_res;
  } vec_t;

  vec_t vecs[16];

  initial begin
    logic [1:0] gid;
    int         waited;

    // rr_ptr evolution noted per row (value before -> after)
    vecs[0]  = '{1'b1, 4'b1111, 32'h04030201, 4'b0001, 8'h01, 8'h02}; // 0->1
    vecs[1]  = '{1'b1, 4'b1111, 32'h04030201, 4'b0010, 8'h02, 8'h04}; // 1->2
    vecs[2]  = '{1'b1, 4'b1111, 32'h04030201, 4'b0100, 8'h03, 8'h06}; // 2->3
    vecs[3]  = '{1'b1, 4'b1111, 32'h04030201, 4'b1000, 8'h04, 8'h08}; // 3->0
    vecs[4]  = '{1'b1, 4'b1111, 32'h04030201, 4'b0001, 8'h01, 8'h02}; // 0->1
    vecs[5]  = '{1'b1, 4'b0000, 32'h04030201, 4'b0000, 8'h00, 8'h00}; // hold 1
    vecs[6]  = '{1'b1, 4'b0100, 32'h000A0000, 4'b0100, 8'h0A, 8'h14}; // 1->3
    vecs[7]  = '{1'b1, 4'b0011, 32'h1111C87F, 4'b0001, 8'h7F, 8'hFE}; // 3->1 (wrap)
    vecs[8]  = '{1'b1, 4'b0010, 32'h0000C800, 4'b0010, 8'hC8, 8'hFF}; // 1->2
    vecs[9]  = '{1'b1, 4'b0101, 32'h55803300, 4'b0100, 8'h80, 8'hFF}; // 2->3
    vecs[10] = '{1'b1, 4'b0001, 32'h55803300, 4'b0001, 8'h00, 8'h00}; // 3->1
    vecs[11] = '{1'b0, 4'b1111, 32'h01020304, 4'b0000, 8'h00, 8'h00}; // hold 1
    vecs[12] = '{1'b1, 4'b1001, 32'h05000006, 4'b1000, 8'h05, 8'h0A}; // 1->0
    vecs[13] = '{1'b1, 4'b1001, 32'h05000006, 4'b0001, 8'h06, 8'h0C}; // 0->1
    vecs[14] = '{1'b1, 4'b0000, 32'h00000000, 4'b0000, 8'h00, 8'h00};
    vecs[15] = '{1'b1, 4'b0000, 32'h00000000, 4'b0000, 8'h00, 8'h00};

    // ---------------- reset ----------------
    rst_n     = 1'b0;
    en        = 1'b1;
    req_valid = 4'b1111;
    req_data  = 32'h04030201;
    force_pv  = 1'b0;
    #1;
    check("rst_req_ready_comb", 32'(req_ready), 32'd0);
    check("rst_pvalid_comb", 32'(pipe_valid_in), 32'd0);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_resp_id", 32'(resp_id), 32'd0);
    check("rst_resp_data", 32'(resp_data), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    rst_n     = 1'b1;
    req_valid = 4'b0000;

    // ---------------- table-driven steps ----------------
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      check_resp(k);
      en        = vecs[k].en;
      req_valid = vecs[k].rv;
      req_data  = vecs[k].data;
      #1;
      check($sformatf("ready_s%0d", k), 32'(req_ready), 32'(vecs[k].exp_ready));
      check($sformatf("pvalid_s%0d", k), 32'(pipe_valid_in), 32'(|vecs[k].exp_ready));
      check($sformatf("pdata_s%0d", k), 32'(pipe_data_in), 32'(vecs[k].exp_pdata));
      if (vecs[k].exp_ready != 4'b0000) begin
        gid = 2'd0;
        for (int i = 0; i < 4; i++) begin
          if (vecs[k].exp_ready[i]) gid = 2'(i);
        end
        exp_q.push_back({8'(k + 2), gid, vecs[k].exp_res});
      end
    end
    for (int k = 16; k < 18; k++) begin
      @(negedge clk);
      check_resp(k);
      req_valid = 4'b0000;
    end
    check("sb_drained", 32'(exp_q.size()), 32'd0);

    // ---------------- en dropped for 3 cycles (rr_ptr = 1) ----------------
    @(negedge clk);
    en        = 1'b1;
    req_valid = 4'b1111;
    req_data  = 32'h04030201;
    #1;
    check("en_pre_ready", 32'(req_ready), 32'b0010);
    @(negedge clk);
    en = 1'b0;
    #1;
    check("en_off1_ready", 32'(req_ready), 32'd0);
    check("en_off1_pvalid", 32'(pipe_valid_in), 32'd0);
    check("en_off1_busy", 32'(busy), 32'd1);
    @(negedge clk);
    #1;
    check("en_off2_ready", 32'(req_ready), 32'd0);
    check("en_off2_resp_valid", 32'(resp_valid), 32'd1);
    check("en_off2_resp_id", 32'(resp_id), 32'd1);
    check("en_off2_resp_data", 32'(resp_data), 32'h04);
    check("en_off2_busy", 32'(busy), 32'd1);
    @(negedge clk);
    #1;
    check("en_off3_ready", 32'(req_ready), 32'd0);
    check("en_off3_resp_valid", 32'(resp_valid), 32'd0);
    check("en_off3_busy", 32'(busy), 32'd0);
    en = 1'b1;
    #1;
    check("en_resume_ready", 32'(req_ready), 32'b0100);
    @(negedge clk);
    req_valid = 4'b0000;
    waited = 0;
    while (resp_valid !== 1'b1 && waited < 5) begin
      @(negedge clk);
      waited++;
    end
    check("en_resume_resp_valid", 32'(resp_valid), 32'd1);
    check("en_resume_resp_id", 32'(resp_id), 32'd2);
    check("en_resume_resp_data", 32'(resp_data), 32'h06);

    // ---------------- spurious pipe valid -> sticky err ----------------
    @(negedge clk);
    check("err_before_force", 32'(err), 32'd0);
    force_pv = 1'b1;
    @(negedge clk);
    force_pv = 1'b0;
    #1;
    check("err_set", 32'(err), 32'd1);
    check("err_no_resp", 32'(resp_valid), 32'd0);
    repeat (3) @(negedge clk);
    check("err_sticky", 32'(err), 32'd1);
    check("err_sticky_no_resp", 32'(resp_valid), 32'd0);

    // ---------------- reset with a result in flight (rr_ptr = 3) ----------------
    @(negedge clk);
    req_valid = 4'b1000;
    req_data  = 32'h09000000;
    #1;
    check("inflight_ready", 32'(req_ready), 32'b1000);
    @(negedge clk);
    rst_n     = 1'b0;
    req_valid = 4'b1111;
    #1;
    check("midrst_ready", 32'(req_ready), 32'd0);
    check("midrst_pvalid", 32'(pipe_valid_in), 32'd0);
    @(negedge clk);
    rst_n     = 1'b1;
    req_valid = 4'b0000;
    force_pv  = 1'b1;   // stale pipe result emerging just after release
    #1;
    check("postrst_resp_valid", 32'(resp_valid), 32'd0);
    check("postrst_err_cleared", 32'(err), 32'd0);
    check("postrst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    force_pv = 1'b0;
    #1;
    check("mask_err", 32'(err), 32'd0);
    check("mask_resp_valid", 32'(resp_valid), 32'd0);
    req_valid = 4'b1111;
    req_data  = 32'h04030201;
    #1;
    check("postrst_first_grant", 32'(req_ready), 32'b0001);
    @(negedge clk);
    req_valid = 4'b0000;
    @(negedge clk);
    check("postrst_resp_valid2", 32'(resp_valid), 32'd1);
    check("postrst_resp_id", 32'(resp_id), 32'd0);
    check("postrst_resp_data", 32'(resp_data), 32'h02);
    check("postrst_err_final", 32'(err), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
